// File: rtl/segment_transition_ctl_if.sv
// Request/status bundle between the register file (master) and segment_transition_ctl (slave).
interface segment_transition_ctl_if #(
  parameter int SEG_W  = 2,
  parameter int REP_W  = 16,
  parameter int TIME_W = 56
);
  logic              UPDATE;
  logic [SEG_W-1:0]  REQ_SEGMENT;
  logic [REP_W-1:0]  REQ_REP;
  logic [7:0]        TRANSITION_MODE;
  logic [63:0]       TRANSITION_VALUE;
  logic [TIME_W-1:0] SYS_TIME;
  logic              LOOP_DONE;
  logic [3:0]        GPIO_IN;
  logic [SEG_W-1:0]  SEGMENT;
  logic              SWAPPED;
  logic              STOP;
  logic              BUSY;
  logic              REQ_ERR;

  modport master (
    output UPDATE, REQ_SEGMENT, REQ_REP, TRANSITION_MODE, TRANSITION_VALUE,
           SYS_TIME, LOOP_DONE, GPIO_IN,
    input  SEGMENT, SWAPPED, STOP, BUSY, REQ_ERR
  );

  modport slave (
    input  UPDATE, REQ_SEGMENT, REQ_REP, TRANSITION_MODE, TRANSITION_VALUE,
           SYS_TIME, LOOP_DONE, GPIO_IN,
    output SEGMENT, SWAPPED, STOP, BUSY, REQ_ERR
  );
endinterface

// File: rtl/segment_transition_ctl.sv
// Latches a segment-change request and swaps the active segment when its trigger fires.
// Define SEGMENT_TRANSITION_GPIO_EN to include the GPIO trigger (synchroniser + edge detector).
module segment_transition_ctl #(
  parameter int NUM_SEGMENT = 4,
  parameter int SEG_W       = $clog2(NUM_SEGMENT),
  parameter int REP_W       = 16,
  parameter int TIME_W      = 56
) (
  input logic                     CLK,
  input logic                     RST_N,
  segment_transition_ctl_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_AUTO, ST_STOPPED} state_t;
  typedef enum logic [1:0] {TRIG_SYNC, TRIG_TIME, TRIG_GPIO, TRIG_EXT} trig_t;

  localparam logic [SEG_W:0]   SEG_LIMIT = (SEG_W+1)'(NUM_SEGMENT);
  localparam logic [SEG_W-1:0] SEG_LAST  = SEG_W'(NUM_SEGMENT - 1);

  state_t            state_q, state_d;
  trig_t             trig_q, trig_d, req_trig;
  logic [SEG_W-1:0]  seg_q, seg_d, pend_seg_q, pend_seg_d;
  logic [REP_W-1:0]  rep_q, rep_d, pend_rep_q, pend_rep_d;
  logic [TIME_W-1:0] deadline_q, deadline_d;
  logic [1:0]        pin_q, pin_d;
  logic              kick_q, kick_d;
  logic              swapped_q, swapped_d;
  logic              stop_q, stop_d;
  logic              req_err_q, req_err_d;
  logic              req_ok, fire, gpio_fire;
  logic              unused_value;

  assign unused_value = ^bus.TRANSITION_VALUE;

`ifdef SEGMENT_TRANSITION_GPIO_EN
  logic [3:0] gpio_meta_q, gpio_sync_q, gpio_prev_q, gpio_edge_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gpio_meta_q <= '0;
      gpio_sync_q <= '0;
      gpio_prev_q <= '0;
      gpio_edge_q <= '0;
    end else begin
      gpio_meta_q <= bus.GPIO_IN;
      gpio_sync_q <= gpio_meta_q;
      gpio_prev_q <= gpio_sync_q;
      gpio_edge_q <= gpio_sync_q & ~gpio_prev_q;
    end
  end

  assign gpio_fire = gpio_edge_q[pin_q];
`else
  logic unused_gpio;
  assign unused_gpio = ^{bus.GPIO_IN, pin_q};
  assign gpio_fire   = 1'b0;
`endif

  always_comb begin
    case (bus.TRANSITION_MODE)
      8'h01:   req_trig = TRIG_TIME;
`ifdef SEGMENT_TRANSITION_GPIO_EN
      8'h02:   req_trig = TRIG_GPIO;
`endif
      8'hF0:   req_trig = TRIG_EXT;
      default: req_trig = TRIG_SYNC;
    endcase
  end

  assign req_ok = ({1'b0, bus.REQ_SEGMENT} < SEG_LIMIT);

  always_comb begin
    case (trig_q)
      TRIG_TIME: fire = (bus.SYS_TIME >= deadline_q);
      TRIG_GPIO: fire = gpio_fire;
      TRIG_EXT:  fire = 1'b0;
      default:   fire = bus.LOOP_DONE | kick_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    rep_d      = rep_q;
    stop_d     = stop_q;
    kick_d     = kick_q;
    trig_d     = trig_q;
    pend_seg_d = pend_seg_q;
    pend_rep_d = pend_rep_q;
    deadline_d = deadline_q;
    pin_d      = pin_q;
    swapped_d  = 1'b0;
    req_err_d  = bus.UPDATE & ~req_ok;

    if (bus.UPDATE && req_ok) begin
      trig_d     = req_trig;
      pend_seg_d = bus.REQ_SEGMENT;
      pend_rep_d = bus.REQ_REP;
      deadline_d = bus.TRANSITION_VALUE[TIME_W-1:0];
      pin_d      = bus.TRANSITION_VALUE[1:0];
      // A stopped sampler emits no LOOP_DONE, so a sync request must fire on its own
      kick_d     = (req_trig == TRIG_EXT) | stop_q;
      state_d    = (req_trig == TRIG_EXT) ? ST_AUTO : ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (fire) begin
            seg_d     = pend_seg_q;
            rep_d     = pend_rep_q;
            swapped_d = 1'b1;
            stop_d    = 1'b0;
            kick_d    = 1'b0;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.LOOP_DONE && (rep_q != '1)) begin
            if (rep_q == '0) begin
              stop_d  = 1'b1;
              state_d = ST_STOPPED;
            end else begin
              rep_d = rep_q - 1'b1;
            end
          end
        end
        ST_AUTO: begin
          if (kick_q) begin
            seg_d     = pend_seg_q;
            swapped_d = 1'b1;
            stop_d    = 1'b0;
            kick_d    = 1'b0;
          end else if (bus.LOOP_DONE) begin
            seg_d     = (seg_q == SEG_LAST) ? '0 : seg_q + 1'b1;
            swapped_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_RUN;
      trig_q     <= TRIG_SYNC;
      seg_q      <= '0;
      rep_q      <= '1;
      pend_seg_q <= '0;
      pend_rep_q <= '0;
      deadline_q <= '0;
      pin_q      <= '0;
      kick_q     <= 1'b0;
      swapped_q  <= 1'b0;
      stop_q     <= 1'b0;
      req_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      seg_q      <= seg_d;
      rep_q      <= rep_d;
      pend_seg_q <= pend_seg_d;
      pend_rep_q <= pend_rep_d;
      deadline_q <= deadline_d;
      pin_q      <= pin_d;
      kick_q     <= kick_d;
      swapped_q  <= swapped_d;
      stop_q     <= stop_d;
      req_err_q  <= req_err_d;
    end
  end

  assign bus.SEGMENT = seg_q;
  assign bus.SWAPPED = swapped_q;
  assign bus.STOP    = stop_q;
  assign bus.BUSY    = (state_q == ST_WAIT);
  assign bus.REQ_ERR = req_err_q;

endmodule
